// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached RAM controller: command opcodes and word widths.
package spi_ram_pkg;

    localparam int unsigned RX_WIDTH   = 10;
    localparam int unsigned DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_e;

endpackage

// File: rtl/sp_ram_core.sv
// Single-port storage array: synchronous write, registered read, no reset on contents.
module sp_ram_core #(
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_SIZE-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;

    // Read returns the old contents on a same-address write (read-first).
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout_q <= mem_q[addr];
    end

    assign dout = dout_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder and RAM front-end for the SPI slave: acts once per rx_valid rising edge,
// returns read data on tx_data/tx_valid and pulses cmd_err on out-of-order commands.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter bit          AUTO_INC  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RX_WIDTH-1:0]   rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  cmd_err
);

    opcode_e               op;
    logic [DATA_WIDTH-1:0] payload;
    logic                  cmd_fire;

    logic                  rx_valid_q, rx_valid_d;
    logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
    logic                  wr_addr_vld_q, wr_addr_vld_d;
    logic                  rd_addr_vld_q, rd_addr_vld_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  cmd_err_q, cmd_err_d;

    logic                  ram_we;
    logic [ADDR_SIZE-1:0]  ram_addr;
    logic [DATA_WIDTH-1:0] ram_dout;

    assign op       = opcode_e'(rx_data[RX_WIDTH-1 -: 2]);
    assign payload  = rx_data[DATA_WIDTH-1:0];
    assign cmd_fire = rx_valid & ~rx_valid_q;

    always_comb begin
        rx_valid_d    = rx_valid;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_vld_d = wr_addr_vld_q;
        rd_addr_vld_d = rd_addr_vld_q;
        tx_valid_d    = tx_valid_q;
        rd_pend_d     = 1'b0;
        cmd_err_d     = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = wr_addr_q;

        // tx_valid follows the SPI transaction: once rx_valid drops, the read is over.
        if (!rx_valid) begin
            tx_valid_d = 1'b0;
        end

        if (cmd_fire) begin
            tx_valid_d = 1'b0;
            unique case (op)
                OP_WR_ADDR: begin
                    wr_addr_d     = payload[ADDR_SIZE-1:0];
                    wr_addr_vld_d = 1'b1;
                end
                OP_WR_DATA: begin
                    ram_addr = wr_addr_q;
                    if (wr_addr_vld_q) begin
                        ram_we = 1'b1;
                        if (AUTO_INC) begin
                            wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
                        end
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                OP_RD_ADDR: begin
                    rd_addr_d     = payload[ADDR_SIZE-1:0];
                    rd_addr_vld_d = 1'b1;
                    ram_addr      = rd_addr_q;
                end
                OP_RD_DATA: begin
                    ram_addr = rd_addr_q;
                    if (rd_addr_vld_q) begin
                        tx_valid_d = 1'b1;
                        rd_pend_d  = 1'b1;
                        if (AUTO_INC) begin
                            rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
                        end
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The RAM read register lands one cycle after the RD_DATA edge; capture it then so
    // tx_data keeps its value while the RAM port is reused and resets cleanly to zero.
    assign tx_hold_d = rd_pend_q ? ram_dout : tx_hold_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            wr_addr_vld_q <= 1'b0;
            rd_addr_vld_q <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_hold_q     <= '0;
            rd_pend_q     <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            rx_valid_q    <= rx_valid_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_vld_q <= wr_addr_vld_d;
            rd_addr_vld_q <= rd_addr_vld_d;
            tx_valid_q    <= tx_valid_d;
            tx_hold_q     <= tx_hold_d;
            rd_pend_q     <= rd_pend_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    sp_ram_core #(
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_SIZE  (ADDR_SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (payload),
        .dout (ram_dout)
    );

    assign tx_data  = rd_pend_q ? ram_dout : tx_hold_q;
    assign tx_valid = tx_valid_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: transaction-level model checked every cycle, plus
// hand-computed expectations on the directed command sequences.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       cmd_err;

    always #5 clk = ~clk;

    spi_ram_ctrl #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8),
        .AUTO_INC  (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err)
    );

    // Model: what a command does, applied once per rising edge of rx_valid.
    logic [7:0] m_mem   [256];
    logic       m_known [256];
    logic [7:0] m_wa, m_ra;
    logic       m_wv, m_rv, m_prev;
    logic       m_txv, m_err, m_txd_known;
    logic [7:0] m_txd;

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = 8'h00;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_wa <= 8'h00; m_ra <= 8'h00; m_wv <= 1'b0; m_rv <= 1'b0; m_prev <= 1'b0;
            m_txv <= 1'b0; m_txd <= 8'h00; m_txd_known <= 1'b1; m_err <= 1'b0;
        end else begin
            m_err  <= 1'b0;
            m_prev <= rx_valid;
            if (!rx_valid) m_txv <= 1'b0;
            if (rx_valid && !m_prev) begin
                m_txv <= 1'b0;
                case (rx_data[9:8])
                    2'b00: begin m_wa <= rx_data[7:0]; m_wv <= 1'b1; end
                    2'b01: begin
                        if (m_wv) begin
                            m_mem[m_wa]   <= rx_data[7:0];
                            m_known[m_wa] <= 1'b1;
                            m_wa          <= m_wa + 8'd1;
                        end else m_err <= 1'b1;
                    end
                    2'b10: begin m_ra <= rx_data[7:0]; m_rv <= 1'b1; end
                    default: begin
                        if (m_rv) begin
                            m_txv       <= 1'b1;
                            m_txd       <= m_mem[m_ra];
                            m_txd_known <= m_known[m_ra];
                            m_ra        <= m_ra + 8'd1;
                        end else m_err <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Directed expectations, written only by the stimulus process, checked by the compare one.
    string      lit_name [128];
    logic [7:0] lit_got  [128];
    logic [7:0] lit_exp  [128];
    int         lit_wr = 0;
    int         lit_rd = 0;
    logic       chk_en = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (tx_valid !== m_txv) begin
                n_fail++;
                $display("FAIL tx_valid @%0t: got %0b, expected %0b", $time, tx_valid, m_txv);
            end
            n_tests++;
            if (cmd_err !== m_err) begin
                n_fail++;
                $display("FAIL cmd_err @%0t: got %0b, expected %0b", $time, cmd_err, m_err);
            end
            if (m_txd_known) begin
                n_tests++;
                if (tx_data !== m_txd) begin
                    n_fail++;
                    $display("FAIL tx_data @%0t: got %02h, expected %02h", $time, tx_data, m_txd);
                end
            end
        end
        while (lit_rd < lit_wr) begin
            n_tests++;
            if (lit_got[lit_rd] !== lit_exp[lit_rd]) begin
                n_fail++;
                $display("FAIL %s: got %02h, expected %02h",
                         lit_name[lit_rd], lit_got[lit_rd], lit_exp[lit_rd]);
            end
            lit_rd++;
        end
    end

    logic [7:0] s_txd;
    logic       s_txv, s_err;

    task automatic lit(input string nm, input logic [7:0] got, input logic [7:0] exp);
        lit_name[lit_wr] = nm;
        lit_got[lit_wr]  = got;
        lit_exp[lit_wr]  = exp;
        lit_wr++;
    endtask

    // One SPI word: rx_valid held `hold` cycles, then dropped; outputs sampled in cycle N+1.
    task automatic word(input logic [1:0] op, input logic [7:0] pl, input int hold);
        rx_data  = {op, pl};
        rx_valid = 1'b1;
        @(posedge clk); #1;
        s_txv = tx_valid; s_txd = tx_data; s_err = cmd_err;
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 10'h000;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        lit("reset tx_valid", {7'd0, tx_valid}, 8'h00);
        lit("reset tx_data", tx_data, 8'h00);

        // Data commands before any address was set.
        word(2'b01, 8'h77, 2);
        lit("early WR_DATA err", {7'd0, s_err}, 8'h01);
        word(2'b11, 8'h00, 2);
        lit("early RD_DATA err", {7'd0, s_err}, 8'h01);
        lit("early RD_DATA txv", {7'd0, s_txv}, 8'h00);

        // Basic write / read-back.
        word(2'b00, 8'h12, 1);
        word(2'b01, 8'hA5, 1);
        word(2'b10, 8'h12, 1);
        word(2'b11, 8'h00, 3);
        lit("rd 0x12 txv", {7'd0, s_txv}, 8'h01);
        lit("rd 0x12 data", s_txd, 8'hA5);
        lit("txv drop after rx low", {7'd0, tx_valid}, 8'h00);
        lit("tx_data holds", tx_data, 8'hA5);

        // Long-held WR_DATA writes once.
        word(2'b00, 8'h41, 1);
        word(2'b01, 8'h5A, 1);
        word(2'b00, 8'h40, 1);
        word(2'b01, 8'h3C, 6);
        word(2'b10, 8'h40, 1);
        word(2'b11, 8'h00, 2);
        lit("rd 0x40", s_txd, 8'h3C);
        word(2'b11, 8'h00, 2);
        lit("rd 0x41 prior", s_txd, 8'h5A);
        word(2'b01, 8'h99, 1);
        word(2'b10, 8'h41, 1);
        word(2'b11, 8'h00, 2);
        lit("wr_addr was 0x41", s_txd, 8'h99);

        // Address wrap at the top of memory.
        word(2'b00, 8'hFF, 1);
        word(2'b01, 8'h11, 1);
        word(2'b01, 8'h22, 1);
        word(2'b01, 8'h33, 1);
        word(2'b10, 8'hFF, 1);
        word(2'b11, 8'h00, 1);
        lit("rd 0xFF", s_txd, 8'h11);
        word(2'b11, 8'h00, 1);
        lit("rd 0x00 wrap", s_txd, 8'h22);
        word(2'b11, 8'h00, 1);
        lit("rd 0x01 wrap", s_txd, 8'h33);

        // Sequential reads with auto-increment.
        word(2'b00, 8'h05, 1);
        word(2'b01, 8'hAA, 1);
        word(2'b01, 8'hBB, 1);
        word(2'b10, 8'h05, 1);
        word(2'b11, 8'h00, 2);
        lit("rd 0x05", s_txd, 8'hAA);
        word(2'b11, 8'h00, 2);
        lit("rd 0x06", s_txd, 8'hBB);
        lit("rd 0x06 no err", {7'd0, s_err}, 8'h00);

        // Reset in the middle of a read, rx_valid still high through release.
        word(2'b10, 8'h05, 1);
        rx_data  = {2'b11, 8'h00};
        rx_valid = 1'b1;
        @(posedge clk); #1;
        lit("mid-read txv", {7'd0, tx_valid}, 8'h01);
        lit("mid-read data", tx_data, 8'hAA);
        rst_n = 1'b0;
        @(posedge clk); #1;
        lit("reset txv", {7'd0, tx_valid}, 8'h00);
        lit("reset data", tx_data, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        lit("post-reset RD_DATA err", {7'd0, cmd_err}, 8'h01);
        lit("post-reset txv", {7'd0, tx_valid}, 8'h00);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        lit("err one cycle", {7'd0, cmd_err}, 8'h00);
        word(2'b01, 8'h55, 1);
        lit("post-reset WR_DATA err", {7'd0, s_err}, 8'h01);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
